uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver state encoding and
// the oversampling divider computation used by the baud tick generator.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Returns 0 for an unusable parameter set so the caller can refuse to elaborate.
    function automatic int calc_os_div(input int clk_freq, input int baud_rate,
                                       input int oversample);
        if (oversample < 8 || baud_rate < 1) return 0;
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte channel: 1-deep valid/ready buffer between the UART receiver
// and its consumer.
interface uart_rx_if
    import uart_pkg::*;
();

    logic [UART_DATA_BITS-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle os_tick every OS_DIV clocks while
// enabled, restartable from zero with clr so ticks align to a frame edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic os_tick
);

    localparam int OS_DIV = calc_os_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(OS_DIV - 1);

    if (OS_DIV < 1) begin : g_param_check
        $error("uart_baud_tick: OVERSAMPLE must be >= 8 and CLK_FREQ/(BAUD_RATE*OVERSAMPLE) >= 1");
    end

    logic [CW-1:0] div_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == TERMINAL) ? '0 : div_cnt + CW'(1);
        end
    end

    assign os_tick = en && !clr && (div_cnt == TERMINAL);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and a
// 1-deep valid/ready output buffer; framing and overrun errors are pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master out_if,
    output logic      frame_err,
    output logic      overrun_err,
    output logic      busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [SW-1:0] IDX_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] IDX_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] IDX_C    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] IDX_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

    logic                      rx_meta;
    logic                      rx_s;
    rx_state_e                 state;
    logic [SW-1:0]             sample_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      samp_a;
    logic                      samp_b;
    logic                      os_tick;
    logic                      majority;
    logic                      decide;
    logic                      wrap;
    logic                      start_edge;

    // Idle-high reset value keeps a reset release from looking like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {rx_meta, rx_s} <= 2'b11;
        else     {rx_meta, rx_s} <= {rx, rx_meta};
    end

    assign start_edge = (state == IDLE) && !rx_s;
    assign decide     = os_tick && (sample_cnt == IDX_C);
    assign wrap       = os_tick && (sample_cnt == IDX_LAST);
    assign majority   = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign busy       = (state != IDLE);

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (state != IDLE),
        .clr    (start_edge),
        .os_tick(os_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            sample_cnt       <= '0;
            bit_cnt          <= '0;
            shreg            <= '0;
            samp_a           <= 1'b1;
            samp_b           <= 1'b1;
            out_if.out_data  <= '0;
            out_if.out_valid <= 1'b0;
            frame_err        <= 1'b0;
            overrun_err      <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;

            if (out_if.out_valid && out_if.out_ready) out_if.out_valid <= 1'b0;

            if (os_tick) begin
                sample_cnt <= wrap ? '0 : sample_cnt + SW'(1);
                if (sample_cnt == IDX_A) samp_a <= rx_s;
                if (sample_cnt == IDX_B) samp_b <= rx_s;
            end

            case (state)
                IDLE: begin
                    sample_cnt <= '0;
                    bit_cnt    <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (decide && majority) state <= IDLE;
                    else if (wrap)          state <= DATA;
                end
                DATA: begin
                    if (decide) shreg <= {majority, shreg[UART_DATA_BITS-1:1]};
                    if (wrap) begin
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) state <= STOP;
                    end
                end
                // Stop bit acts at the decision point so the next start edge is never missed.
                STOP: begin
                    if (decide) begin
                        if (!majority) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end else begin
                            if (!out_if.out_valid || out_if.out_ready) begin
                                out_if.out_data  <= shreg;
                                out_if.out_valid <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives 8N1 frames at 432 clk/bit (and skewed
// rates) and checks bytes, handshake, glitch, framing, overrun and reset.
module tb_uart_rx;

    localparam int BIT_CLKS = 432;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic frame_err;
    logic overrun_err;
    logic busy;

    uart_rx_if u_if ();

    uart_rx u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .out_if     (u_if),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Passive monitor: records accepted bytes and counts pulses/valid cycles.
    logic [7:0] got[$];
    int         valid_cycles = 0;
    int         fe_cnt       = 0;
    int         ov_cnt       = 0;

    always @(negedge clk) begin
        if (u_if.out_valid) valid_cycles++;
        if (u_if.out_valid && u_if.out_ready) got.push_back(u_if.out_data);
        if (frame_err) fe_cnt++;
        if (overrun_err) ov_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int n, input logic stop_bit);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(b[i], n);
        drive_bit(stop_bit, n);
        rx = 1'b1;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 u_if.out_ready = v;
        @(negedge clk);
    endtask

    int base_got;
    int base_vc;
    int base_fe;
    int base_ov;

    initial begin
        u_if.out_ready = 1'b0;
        #1 rst = 1'b1;
        idle(5);
        check("reset_out_data",    u_if.out_data,  0);
        check("reset_out_valid",   u_if.out_valid, 0);
        check("reset_frame_err",   frame_err,      0);
        check("reset_overrun_err", overrun_err,    0);
        check("reset_busy",        busy,           0);
        rst = 1'b0;
        idle(20);

        // Single byte with consumer always ready
        set_ready(1'b1);
        base_got = got.size(); base_vc = valid_cycles; base_fe = fe_cnt;
        send_frame(8'hA5, BIT_CLKS, 1'b1);
        idle(500);
        check("a5_count",        got.size() - base_got,    1);
        check("a5_data",         got[base_got],            8'hA5);
        check("a5_valid_cycles", valid_cycles - base_vc,   1);
        check("a5_frame_err",    fe_cnt - base_fe,         0);
        check("a5_busy_idle",    busy,                     0);

        // Back-to-back frames with no idle gap
        base_got = got.size(); base_fe = fe_cnt; base_ov = ov_cnt;
        send_frame(8'h00, BIT_CLKS, 1'b1);
        send_frame(8'hFF, BIT_CLKS, 1'b1);
        send_frame(8'h55, BIT_CLKS, 1'b1);
        idle(500);
        check("b2b_count",   got.size() - base_got, 3);
        check("b2b_byte0",   got[base_got],         8'h00);
        check("b2b_byte1",   got[base_got + 1],     8'hFF);
        check("b2b_byte2",   got[base_got + 2],     8'h55);
        check("b2b_fe",      fe_cnt - base_fe,      0);
        check("b2b_ov",      ov_cnt - base_ov,      0);

        // 100-clk low glitch on an idle line is rejected
        base_got = got.size(); base_fe = fe_cnt;
        rx = 1'b0;
        idle(50);
        check("glitch_busy_mid", busy, 1);
        idle(50);
        rx = 1'b1;
        idle(600);
        check("glitch_no_byte",  got.size() - base_got, 0);
        check("glitch_no_fe",    fe_cnt - base_fe,      0);
        check("glitch_idle",     busy,                  0);

        // Framing error, then recovery on a good frame
        base_got = got.size(); base_fe = fe_cnt;
        send_frame(8'h3C, BIT_CLKS, 1'b0);
        idle(600);
        check("fe_pulses",   fe_cnt - base_fe,      1);
        check("fe_no_byte",  got.size() - base_got, 0);
        check("fe_idle",     busy,                  0);
        send_frame(8'h12, BIT_CLKS, 1'b1);
        idle(500);
        check("fe_recover_count", got.size() - base_got, 1);
        check("fe_recover_data",  got[base_got],         8'h12);
        check("fe_recover_no_fe", fe_cnt - base_fe,      1);

        // Overrun: consumer stalled across two frames
        set_ready(1'b0);
        base_got = got.size(); base_ov = ov_cnt;
        send_frame(8'h11, BIT_CLKS, 1'b1);
        idle(100);
        send_frame(8'h22, BIT_CLKS, 1'b1);
        idle(500);
        check("ovr_hold_data",  u_if.out_data,         8'h11);
        check("ovr_hold_valid", u_if.out_valid,        1);
        check("ovr_pulses",     ov_cnt - base_ov,      1);
        check("ovr_no_accept",  got.size() - base_got, 0);
        set_ready(1'b1);
        idle(10);
        check("ovr_drain_count", got.size() - base_got, 1);
        check("ovr_drain_data",  got[base_got],         8'h11);
        check("ovr_drain_valid", u_if.out_valid,        0);

        // +/-3% bit-period skew
        base_got = got.size(); base_fe = fe_cnt;
        send_frame(8'h96, 419, 1'b1);
        idle(500);
        send_frame(8'h96, 445, 1'b1);
        idle(500);
        check("skew_count", got.size() - base_got, 2);
        check("skew_fast",  got[base_got],         8'h96);
        check("skew_slow",  got[base_got + 1],     8'h96);
        check("skew_fe",    fe_cnt - base_fe,      0);

        // Reset in the middle of the data bits aborts immediately
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b1, 300);
        check("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_data",  u_if.out_data,  0);
        check("mid_rst_out_valid", u_if.out_valid, 0);
        check("mid_rst_busy",      busy,           0);
        check("mid_rst_frame_err", frame_err,      0);
        idle(3);
        rx  = 1'b1;
        rst = 1'b0;
        idle(50);
        base_got = got.size(); base_fe = fe_cnt;
        send_frame(8'h7E, BIT_CLKS, 1'b1);
        idle(500);
        check("post_rst_count", got.size() - base_got, 1);
        check("post_rst_data",  got[base_got],         8'h7E);
        check("post_rst_fe",    fe_cnt - base_fe,      0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
